// File: rtl/fmps_test_link_pkg.sv
// Shared definitions for the FMPS test link reader: status codes, FSM states
// and the default header magic.
package fmps_test_link_pkg;

  localparam logic [1:0] FMPS_ST_OK    = 2'd0;
  localparam logic [1:0] FMPS_ST_MAGIC = 2'd1;
  localparam logic [1:0] FMPS_ST_LEN   = 2'd2;
  localparam logic [1:0] FMPS_ST_SEQ   = 2'd3;

  localparam logic [15:0] FMPS_DEFAULT_MAGIC = 16'hB6CF;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_DATA   = 2'd1,
    ST_DRAIN  = 2'd2
  } fmps_state_e;

endpackage

// File: rtl/fmps_test_link_reader_if.sv
// AXI-Stream receive channel of the FMPS test link; the writer side is the
// master, the reader is the slave.
interface fmps_test_link_reader_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fmps_sat_counter.sv
// Saturating up-counter with synchronous clear; next_o exposes the value the
// counter would take this cycle so a parent can capture it on clear.
module fmps_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    if (inc_i && (count_q != MAX_COUNT)) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/fmps_test_link_reader.sv
// FMPS test link receive endpoint: validates magic, length and index sequence
// and delivers packets. Optional feature macro: FMPS_READER_SEQ_CHECK_EN.
module fmps_test_link_reader
  import fmps_test_link_pkg::*;
#(
  parameter int          MAGIC_WIDTH     = 16,
  parameter int          MAGIC_START_BIT = 16,
  parameter int          INDEX_WIDTH     = 5,
  parameter int          INDEX_START_BIT = 10,
  parameter int          NUM_DATA_WORDS  = 1,
  parameter logic [MAGIC_WIDTH-1:0] EXPECTED_MAGIC = MAGIC_WIDTH'(FMPS_DEFAULT_MAGIC)
) (
  input  logic                          auroraUserClk,
  input  logic                          auroraReset,
  input  logic                          auroraChannelUp,
  input  logic                          auroraFAstrobe,
  fmps_test_link_reader_if.slave        FMPS_TEST_AXI_STREAM_RX,
  output logic                          statusStrobe,
  output logic [1:0]                    statusCode,
  output logic                          packetStrobe,
  output logic [INDEX_WIDTH-1:0]        packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0]  packetData,
  output logic [7:0]                    cyclePacketCount,
  output logic [15:0]                   errorCount
);

  localparam int CNT_W = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);

  fmps_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            word_cnt_q, word_cnt_d;
  logic [INDEX_WIDTH-1:0]      hdr_idx_q, hdr_idx_d;
  logic [32*NUM_DATA_WORDS-1:0] buf_q, buf_d;
  logic                        tready_q;

  logic                        st_fire_d;
  logic [1:0]                  st_code_d;
  logic                        deliver_d;
  logic                        seq_ok_s;

  logic                        status_strobe_q;
  logic [1:0]                  status_code_q;
  logic                        packet_strobe_q;
  logic [INDEX_WIDTH-1:0]      packet_index_q;
  logic [32*NUM_DATA_WORDS-1:0] packet_data_q;
  logic [7:0]                  cycle_count_q;
  logic [7:0]                  run_count_s, run_next_s;

  logic                        accept_s;
  logic [MAGIC_WIDTH-1:0]      magic_s;
  logic [INDEX_WIDTH-1:0]      index_s;

  assign accept_s = FMPS_TEST_AXI_STREAM_RX.tvalid & tready_q;
  assign magic_s  = FMPS_TEST_AXI_STREAM_RX.tdata[MAGIC_START_BIT +: MAGIC_WIDTH];
  assign index_s  = FMPS_TEST_AXI_STREAM_RX.tdata[INDEX_START_BIT +: INDEX_WIDTH];
  assign FMPS_TEST_AXI_STREAM_RX.tready = tready_q;

`ifdef FMPS_READER_SEQ_CHECK_EN
  logic [INDEX_WIDTH-1:0] exp_idx_q;

  assign seq_ok_s = (hdr_idx_q == exp_idx_q);

  // Both match and resync land on received index + 1, so one update covers both.
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      exp_idx_q <= '0;
    end else if (auroraFAstrobe) begin
      exp_idx_q <= '0;
    end else if (deliver_d) begin
      exp_idx_q <= hdr_idx_q + INDEX_WIDTH'(1);
    end else begin
      exp_idx_q <= exp_idx_q;
    end
  end
`else
  assign seq_ok_s = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    hdr_idx_d  = hdr_idx_q;
    buf_d      = buf_q;
    st_fire_d  = 1'b0;
    st_code_d  = FMPS_ST_OK;
    deliver_d  = 1'b0;
    if (!auroraChannelUp) begin
      state_d = ST_HEADER;
      if (state_q == ST_DATA) begin
        st_fire_d = 1'b1;
        st_code_d = FMPS_ST_LEN;
      end else begin
        st_fire_d = 1'b0;
      end
    end else if (accept_s) begin
      case (state_q)
        ST_HEADER: begin
          if (magic_s != EXPECTED_MAGIC) begin
            st_fire_d = 1'b1;
            st_code_d = FMPS_ST_MAGIC;
            state_d   = FMPS_TEST_AXI_STREAM_RX.tlast ? ST_HEADER : ST_DRAIN;
          end else if (FMPS_TEST_AXI_STREAM_RX.tlast) begin
            st_fire_d = 1'b1;
            st_code_d = FMPS_ST_LEN;
          end else begin
            hdr_idx_d  = index_s;
            word_cnt_d = '0;
            state_d    = ST_DATA;
          end
        end
        ST_DATA: begin
          buf_d[32*word_cnt_q +: 32] = FMPS_TEST_AXI_STREAM_RX.tdata;
          if (word_cnt_q == LAST_WORD) begin
            st_fire_d = 1'b1;
            if (FMPS_TEST_AXI_STREAM_RX.tlast) begin
              deliver_d = 1'b1;
              st_code_d = seq_ok_s ? FMPS_ST_OK : FMPS_ST_SEQ;
              state_d   = ST_HEADER;
            end else begin
              st_code_d = FMPS_ST_LEN;
              state_d   = ST_DRAIN;
            end
          end else if (FMPS_TEST_AXI_STREAM_RX.tlast) begin
            st_fire_d = 1'b1;
            st_code_d = FMPS_ST_LEN;
            state_d   = ST_HEADER;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (FMPS_TEST_AXI_STREAM_RX.tlast) begin
            state_d = ST_HEADER;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_HEADER;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      state_q    <= ST_HEADER;
      word_cnt_q <= '0;
      hdr_idx_q  <= '0;
      buf_q      <= '0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      hdr_idx_q  <= hdr_idx_d;
      buf_q      <= buf_d;
      tready_q   <= 1'b1;
    end
  end

  // Strobes fire one cycle after the deciding beat; index/data hold between deliveries.
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      status_strobe_q <= 1'b0;
      status_code_q   <= FMPS_ST_OK;
      packet_strobe_q <= 1'b0;
      packet_index_q  <= '0;
      packet_data_q   <= '0;
    end else begin
      status_strobe_q <= st_fire_d;
      packet_strobe_q <= deliver_d;
      if (st_fire_d) begin
        status_code_q <= st_code_d;
      end else begin
        status_code_q <= status_code_q;
      end
      if (deliver_d) begin
        packet_index_q <= hdr_idx_q;
        packet_data_q  <= buf_d;
      end else begin
        packet_index_q <= packet_index_q;
        packet_data_q  <= packet_data_q;
      end
    end
  end

  fmps_sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk_i   (auroraUserClk),
    .rst_i   (auroraReset),
    .clr_i   (1'b0),
    .inc_i   (status_strobe_q && (status_code_q != FMPS_ST_OK)),
    .count_o (errorCount),
    .next_o  ()
  );

  fmps_sat_counter #(.WIDTH(8)) u_run_cnt (
    .clk_i   (auroraUserClk),
    .rst_i   (auroraReset),
    .clr_i   (auroraFAstrobe),
    .inc_i   (packet_strobe_q && (status_code_q == FMPS_ST_OK)),
    .count_o (run_count_s),
    .next_o  (run_next_s)
  );

  // next_o already includes a same-cycle delivery, so it closes the FA cycle.
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      cycle_count_q <= 8'd0;
    end else if (auroraFAstrobe) begin
      cycle_count_q <= run_next_s;
    end else begin
      cycle_count_q <= cycle_count_q;
    end
  end

  assign statusStrobe     = status_strobe_q;
  assign statusCode       = status_code_q;
  assign packetStrobe     = packet_strobe_q;
  assign packetIndex      = packet_index_q;
  assign packetData       = packet_data_q;
  assign cyclePacketCount = cycle_count_q;

endmodule

// File: tb/tb_fmps_test_link_reader.sv
// Directed self-checking bench for fmps_test_link_reader with hand-computed
// expectations; adapts the sequence-check expectations to FMPS_READER_SEQ_CHECK_EN.
module tb_fmps_test_link_reader;
  import fmps_test_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chan_up = 1'b0;
  logic        fa = 1'b0;
  logic        status_strobe, packet_strobe;
  logic [1:0]  status_code;
  logic [4:0]  packet_index;
  logic [31:0] packet_data;
  logic [7:0]  cycle_count;
  logic [15:0] error_count;

  int checks = 0;
  int failures = 0;

  int          pkt_n = 0;
  int          st_cnt [4] = '{0, 0, 0, 0};
  logic [31:0] mon_idx [64];
  logic [31:0] mon_data [64];
  logic [1:0]  mon_code [64];

  fmps_test_link_reader_if rx_if ();

  fmps_test_link_reader dut (
    .auroraUserClk           (clk),
    .auroraReset             (rst),
    .auroraChannelUp         (chan_up),
    .auroraFAstrobe          (fa),
    .FMPS_TEST_AXI_STREAM_RX (rx_if),
    .statusStrobe            (status_strobe),
    .statusCode              (status_code),
    .packetStrobe            (packet_strobe),
    .packetIndex             (packet_index),
    .packetData              (packet_data),
    .cyclePacketCount        (cycle_count),
    .errorCount              (error_count)
  );

  always #5 clk = ~clk;

  // Record every strobe on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (status_strobe) st_cnt[status_code] = st_cnt[status_code] + 1;
    if (packet_strobe && pkt_n < 64) begin
      mon_idx[pkt_n]  = {27'd0, packet_index};
      mon_data[pkt_n] = packet_data;
      mon_code[pkt_n] = status_code;
    end
    if (packet_strobe) pkt_n = pkt_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [15:0] magic, input int idx);
    return {magic, 16'h0000} | ((32'(idx) & 32'h1F) << 10);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = d;
    rx_if.tlast  = last;
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  task automatic fa_pulse();
    fa = 1'b1;
    @(posedge clk); #1;
    fa = 1'b0;
  endtask

  task automatic good_pkt(input int idx, input logic [31:0] d);
    beat(hdr(16'hB6CF, idx), 1'b0);
    beat(d, 1'b1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tready"}, {31'd0, rx_if.tready}, 32'd0);
    check({pfx, "_status_strobe"}, {31'd0, status_strobe}, 32'd0);
    check({pfx, "_packet_strobe"}, {31'd0, packet_strobe}, 32'd0);
    check({pfx, "_status_code"}, {30'd0, status_code}, 32'd0);
    check({pfx, "_packet_index"}, {27'd0, packet_index}, 32'd0);
    check({pfx, "_packet_data"}, packet_data, 32'd0);
    check({pfx, "_cycle_count"}, {24'd0, cycle_count}, 32'd0);
    check({pfx, "_error_count"}, {16'd0, error_count}, 32'd0);
  endtask

  int base;
  int s1, s2;
  int exp_err;

  initial begin
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = 32'd0;
    rx_if.tlast  = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);
    check("tready_after_reset", {31'd0, rx_if.tready}, 32'd1);
    chan_up = 1'b1;
    idle(1);

    // Eight good packets back to back inside one FA cycle.
    fa_pulse();
    base = pkt_n;
    for (int i = 0; i < 8; i++) good_pkt(i, 32'h1000 + 32'(i));
    idle(3);
    check("good_pkt_count", 32'(pkt_n - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("good_idx%0d", i), mon_idx[base+i], 32'(i));
      check($sformatf("good_data%0d", i), mon_data[base+i], 32'h1000 + 32'(i));
      check($sformatf("good_code%0d", i), {30'd0, mon_code[base+i]}, 32'd0);
    end
    fa_pulse();
    idle(1);
    check("cycle_count_8", {24'd0, cycle_count}, 32'd8);
    check("error_count_0", {16'd0, error_count}, 32'd0);

    // Bad magic, then a data beat with tlast that must be drained silently.
    s1 = st_cnt[1];
    base = pkt_n;
    beat(32'hB6CE0000, 1'b0);
    beat(32'hDEAD0001, 1'b1);
    good_pkt(0, 32'h0000ABCD);
    idle(3);
    check("magic_status1", 32'(st_cnt[1] - s1), 32'd1);
    check("magic_pkt_count", 32'(pkt_n - base), 32'd1);
    check("magic_next_data", mon_data[base], 32'h0000ABCD);
    check("magic_err", {16'd0, error_count}, 32'd1);

    // Long packet: header, data (final word without tlast), extra beat with tlast.
    fa_pulse();
    s2 = st_cnt[2];
    base = pkt_n;
    beat(hdr(16'hB6CF, 0), 1'b0);
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b1);
    good_pkt(0, 32'h33333333);
    idle(3);
    check("long_status2", 32'(st_cnt[2] - s2), 32'd1);
    check("long_pkt_count", 32'(pkt_n - base), 32'd1);
    check("long_next_data", mon_data[base], 32'h33333333);
    check("long_next_code", {30'd0, mon_code[base]}, 32'd0);
    check("long_err", {16'd0, error_count}, 32'd2);
    exp_err = 2;

    // Index sequence 0,1,3,4.
    fa_pulse();
    base = pkt_n;
    good_pkt(0, 32'hA0);
    good_pkt(1, 32'hA1);
    good_pkt(3, 32'hA3);
    good_pkt(4, 32'hA4);
    idle(3);
    check("seq_pkt_count", 32'(pkt_n - base), 32'd4);
    check("seq_code0", {30'd0, mon_code[base]}, 32'd0);
    check("seq_code1", {30'd0, mon_code[base+1]}, 32'd0);
`ifdef FMPS_READER_SEQ_CHECK_EN
    check("seq_code3", {30'd0, mon_code[base+2]}, 32'd3);
    exp_err = exp_err + 1;
`else
    check("seq_code3", {30'd0, mon_code[base+2]}, 32'd0);
`endif
    check("seq_code4", {30'd0, mon_code[base+3]}, 32'd0);
    check("seq_idx3", mon_idx[base+2], 32'd3);
    check("seq_err", {16'd0, error_count}, 32'(exp_err));

    // Channel drop after the header beat.
    fa_pulse();
    idle(1);
`ifdef FMPS_READER_SEQ_CHECK_EN
    check("seq_cycle_count", {24'd0, cycle_count}, 32'd3);
`else
    check("seq_cycle_count", {24'd0, cycle_count}, 32'd4);
`endif
    s2 = st_cnt[2];
    base = pkt_n;
    beat(hdr(16'hB6CF, 0), 1'b0);
    chan_up = 1'b0;
    idle(3);
    chan_up = 1'b1;
    idle(2);
    check("chan_status2", 32'(st_cnt[2] - s2), 32'd1);
    check("chan_pkt_count", 32'(pkt_n - base), 32'd0);
    check("chan_err", {16'd0, error_count}, 32'(exp_err + 1));

    // Reset mid-packet returns everything to reset values.
    base = pkt_n;
    beat(hdr(16'hB6CF, 0), 1'b0);
    rst = 1'b1;
    idle(2);
    check_reset_outputs("midreset");
    rst = 1'b0;
    idle(2);
    check("midreset_no_pkt", 32'(pkt_n - base), 32'd0);
    fa_pulse();
    good_pkt(0, 32'h12345678);
    idle(3);
    check("post_reset_pkt_count", 32'(pkt_n - base), 32'd1);
    check("post_reset_data", mon_data[base], 32'h12345678);
    check("post_reset_code", {30'd0, mon_code[base]}, 32'd0);

    // Error counter saturation with single-beat bad-magic packets.
    for (int i = 0; i < 70000; i++) beat(32'hB6CE0000, 1'b1);
    idle(3);
    check("err_saturated", {16'd0, error_count}, 32'h0000FFFF);
    check("sat_no_pkt", 32'(pkt_n - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
